// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_tx
//  Purpose  : Serial frame transmitter. Sends a fixed sync preamble and then
//             a parallel payload word, MSB first, at one bit per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter int                   DATA_W    = 8,
    parameter int                   GAP       = 1
) (
    input  logic              clk,
    input  logic              reset,      // synchronous, active low
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_sync,
    output logic              tx_last,
    output logic              busy
);

    // The counter must hold the largest per-state count without wrapping.
    localparam int c_max_a   = (PATTERN_W > DATA_W) ? PATTERN_W : DATA_W;
    localparam int c_max_len = (c_max_a > GAP) ? c_max_a : GAP;
    localparam int c_cnt_w   = $clog2(c_max_len + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [c_cnt_w-1:0]  cnt_q,     cnt_d;
    logic [DATA_W-1:0]   shreg_q,   shreg_d;
    logic                tx_bit_q,  tx_bit_d;
    logic                tx_valid_q, tx_valid_d;
    logic                tx_sync_q, tx_sync_d;
    logic                tx_last_q, tx_last_d;

    logic                accept;

    assign in_ready = (state_q == ST_IDLE) & reset;
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q != ST_IDLE);
    assign tx_bit   = tx_bit_q;
    assign tx_valid = tx_valid_q;
    assign tx_sync  = tx_sync_q;
    assign tx_last  = tx_last_q;

    // Next-state, counter, shift register and the line bits for the next cycle.
    // Line outputs are computed from the current state and registered, so
    // each bit appears one cycle after its state/count slot.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        tx_bit_d   = 1'b0;
        tx_valid_d = 1'b0;
        tx_sync_d  = 1'b0;
        tx_last_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    state_d = ST_SYNC;
                end
            end

            ST_SYNC: begin
                tx_valid_d = 1'b1;
                tx_sync_d  = 1'b1;
                for (int i = 0; i < PATTERN_W; i++) begin
                    if (int'(cnt_q) == i) begin
                        tx_bit_d = PATTERN[PATTERN_W-1-i];
                    end
                end
                if (int'(cnt_q) == PATTERN_W - 1) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            ST_DATA: begin
                tx_valid_d = 1'b1;
                tx_bit_d   = shreg_q[DATA_W-1];
                shreg_d    = shreg_q << 1;
                if (int'(cnt_q) == DATA_W - 1) begin
                    tx_last_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            ST_GAP: begin
                if (int'(cnt_q) >= GAP - 1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and drops the word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_sync_q  <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            tx_sync_q  <= tx_sync_d;
            tx_last_q  <= tx_last_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_pattern_tx
//  Purpose  : Self-checking bench for seq_pattern_tx (GAP=1 and GAP=0 builds).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, tx_bit, tx_valid, tx_sync, tx_last, busy;

    logic [7:0] in_data0;
    logic       in_valid0;
    logic       in_ready0, tx_bit0, tx_valid0, tx_sync0, tx_last0, busy0;

    seq_pattern_tx #(.PATTERN_W(4), .PATTERN(4'b1011), .DATA_W(8), .GAP(1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx_bit(tx_bit), .tx_valid(tx_valid),
        .tx_sync(tx_sync), .tx_last(tx_last), .busy(busy)
    );

    seq_pattern_tx #(.PATTERN_W(4), .PATTERN(4'b1011), .DATA_W(8), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .tx_bit(tx_bit0), .tx_valid(tx_valid0),
        .tx_sync(tx_sync0), .tx_last(tx_last0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Line monitor: captured on the falling edge, away from the active edge.
    int   acc_q[$];    // cycle index of accepts on dut
    int   acc0_q[$];   // cycle index of accepts on dut0
    bit   bits_q[$];   // valid line bits of dut
    bit   v0_q[$];     // tx_valid0 per cycle (index == cycle)
    int   last_cnt = 0;

    always @(negedge clk) begin
        int cyc;
        cyc = v0_q.size();
        if (in_valid && in_ready)   acc_q.push_back(cyc);
        if (in_valid0 && in_ready0) acc0_q.push_back(cyc);
        if (tx_valid) bits_q.push_back(tx_bit);
        if (tx_last)  last_cnt = last_cnt + 1;
        v0_q.push_back(tx_valid0);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_bits();
        logic [31:0] v;
        v = '0;
        foreach (bits_q[i]) v = {v[30:0], bits_q[i]};
        return v;
    endfunction

    // Returns just after the posedge on which accept number n+1 happened.
    task automatic wait_acc(input int n);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (acc_q.size() > n) return;
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [7:0] data;
        logic [5:0] exp;   // {in_ready, busy, tx_valid, tx_sync, tx_last, tx_bit}
    } vec_t;

    vec_t tv[19];

    initial begin
        int c1, c2, c3, zeros;
        logic [15:0] hits;

        // Reset, release, then one 8'hA5 frame with in_valid held during it.
        tv[0]  = '{1'b0, 1'b1, 8'hA5, 6'b000000};
        tv[1]  = '{1'b0, 1'b1, 8'hA5, 6'b000000};
        tv[2]  = '{1'b0, 1'b1, 8'hA5, 6'b000000};
        tv[3]  = '{1'b1, 1'b0, 8'hA5, 6'b100000};
        tv[4]  = '{1'b1, 1'b1, 8'hA5, 6'b010000};
        tv[5]  = '{1'b1, 1'b1, 8'h00, 6'b011101};
        tv[6]  = '{1'b1, 1'b1, 8'h00, 6'b011100};
        tv[7]  = '{1'b1, 1'b1, 8'h00, 6'b011101};
        tv[8]  = '{1'b1, 1'b1, 8'h00, 6'b011101};
        tv[9]  = '{1'b1, 1'b1, 8'h00, 6'b011001};
        tv[10] = '{1'b1, 1'b1, 8'h00, 6'b011000};
        tv[11] = '{1'b1, 1'b1, 8'h00, 6'b011001};
        tv[12] = '{1'b1, 1'b1, 8'h00, 6'b011000};
        tv[13] = '{1'b1, 1'b1, 8'h00, 6'b011000};
        tv[14] = '{1'b1, 1'b1, 8'h00, 6'b011001};
        tv[15] = '{1'b1, 1'b1, 8'h00, 6'b011000};
        tv[16] = '{1'b1, 1'b1, 8'h00, 6'b011011};
        tv[17] = '{1'b1, 1'b0, 8'h00, 6'b100000};
        tv[18] = '{1'b1, 1'b0, 8'h00, 6'b100000};

        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_valid0 = 1'b0; in_data0 = 8'h00;

        for (int i = 0; i < 19; i++) begin
            reset    = tv[i].rst_n;
            in_valid = tv[i].valid;
            in_data  = tv[i].data;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  {26'd0, in_ready, busy, tx_valid, tx_sync, tx_last, tx_bit},
                  {26'd0, tv[i].exp});
        end

        // Back-to-back FF then 00 with in_valid held high.
        acc_q.delete(); bits_q.delete(); last_cnt = 0;
        in_data = 8'hFF; in_valid = 1'b1;
        wait_acc(0);
        in_data = 8'h00;
        wait_acc(1);
        in_valid = 1'b0;
        if (acc_q.size() >= 2) check("b2b_period", acc_q[1] - acc_q[0], 32'd14);
        repeat (15) @(posedge clk); #1;
        check("b2b_len", bits_q.size(), 32'd24);
        check("b2b_bits", pack_bits(), {8'd0, 4'hB, 8'hFF, 4'hB, 8'h00});
        check("b2b_last", last_cnt, 32'd2);

        // Loopback into a 1011 detector with payload 8'h0B.
        acc_q.delete(); bits_q.delete(); last_cnt = 0;
        in_data = 8'h0B; in_valid = 1'b1;
        wait_acc(0);
        in_valid = 1'b0;
        repeat (15) @(posedge clk); #1;
        hits = '0;
        for (int j = 3; j < bits_q.size() && j < 16; j++)
            if ({bits_q[j-3], bits_q[j-2], bits_q[j-1], bits_q[j]} == 4'b1011) hits[j] = 1'b1;
        check("loop_hits", {16'd0, hits}, 32'h0000_0808);

        // Reset pulse on the third payload bit, then a clean 8'h3C frame.
        acc_q.delete(); bits_q.delete(); last_cnt = 0;
        in_data = 8'h5A; in_valid = 1'b1;
        wait_acc(0);
        in_valid = 1'b0;
        repeat (7) @(posedge clk); #1;
        check("abort_pre", {30'd0, tx_valid, tx_sync}, 32'd2);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_now", {29'd0, tx_valid, busy, in_ready}, 32'd0);
        reset = 1'b1;
        repeat (14) @(posedge clk); #1;
        check("abort_nolast", last_cnt, 32'd0);
        check("abort_len", bits_q.size(), 32'd7);
        acc_q.delete(); bits_q.delete(); last_cnt = 0;
        in_data = 8'h3C; in_valid = 1'b1;
        wait_acc(0);
        in_valid = 1'b0;
        repeat (15) @(posedge clk); #1;
        check("refr_bits", pack_bits(), {20'd0, 4'hB, 8'h3C});
        check("refr_last", last_cnt, 32'd1);

        // GAP=0 build, in_valid held: 13-cycle period, one idle line cycle.
        acc0_q.delete();
        in_data0 = 8'hC3; in_valid0 = 1'b1;
        for (int i = 0; i < 60 && acc0_q.size() < 3; i++) @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        if (acc0_q.size() < 3) begin
            check("gap0_timeout", acc0_q.size(), 32'd3);
        end else begin
            c1 = acc0_q[0]; c2 = acc0_q[1]; c3 = acc0_q[2];
            check("gap0_period1", c2 - c1, 32'd13);
            check("gap0_period2", c3 - c2, 32'd13);
            zeros = 0;
            for (int k = c1 + 1; k <= c3 && k < v0_q.size(); k++)
                if (!v0_q[k]) zeros++;
            check("gap0_idle", zeros, 32'd2);
        end
        repeat (15) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
